fp_align_stage: RTL and testbench

- Two-stage pipelined operand-alignment stage for the single-precision FP adder.
- Sits directly upstream of the right-shifting SHF_unit (LEFT_RIGHT=1, SIZE_DATA=24, SIZE_SHIFT=5).
- Unpacks two IEEE-754 operands, orders them by magnitude, computes the saturated exponent difference, and precomputes the sticky bit for bits the shifter will discard.
- Uses valid/ready handshakes on both sides.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_sticky_gen.sv | 28 ++
 rtl/fp_align_stage.sv | 139 +++++++++++++
 tb/tb_fp_align_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision field widths, unpacked operand type and unpack helper
// for the FP adder datapath.
package fp_pkg;

  localparam int unsigned SIZE_EXP  = 8;
  localparam int unsigned SIZE_MAN  = 23;
  localparam int unsigned SIZE_DATA = SIZE_MAN + 1;

  localparam logic [SIZE_EXP-1:0] EXP_ALL_ONES = '1;

  typedef struct packed {
    logic                 sign;
    logic [SIZE_EXP-1:0]  eff_exp;
    logic [SIZE_DATA-1:0] man;
  } fp_unpacked_t;

  // Denormals and zero use an effective exponent of 1 with the hidden bit cleared.
  function automatic fp_unpacked_t fp_unpack(input logic [SIZE_EXP+SIZE_MAN:0] op);
    fp_unpacked_t        u;
    logic [SIZE_EXP-1:0] e;
    e      = op[SIZE_EXP+SIZE_MAN-1:SIZE_MAN];
    u.sign = op[SIZE_EXP+SIZE_MAN];
    if (e == '0) begin
      u.eff_exp = SIZE_EXP'(1);
      u.man     = {1'b0, op[SIZE_MAN-1:0]};
    end else begin
      u.eff_exp = e;
      u.man     = {1'b1, op[SIZE_MAN-1:0]};
    end
    return u;
  endfunction

endpackage

// File: rtl/fp_sticky_gen.sv
// Sticky bit for a right shift by i_diff: OR of the mantissa bits that fall off
// the bottom. Shift amounts at or beyond the mantissa width discard everything.
module fp_sticky_gen #(
  parameter int unsigned SIZE_DATA = 24,
  parameter int unsigned SIZE_EXP  = 8
) (
  input  logic [SIZE_DATA-1:0] i_man,
  input  logic [SIZE_EXP-1:0]  i_diff,
  output logic                 o_sticky
);

  localparam logic [SIZE_EXP-1:0]  DATA_W = SIZE_EXP'(SIZE_DATA);
  localparam logic [SIZE_DATA-1:0] ONES   = '1;

  logic [SIZE_DATA-1:0] w_mask;

  always_comb begin
    w_mask = '0;
    if (i_diff >= DATA_W) begin
      w_mask = '1;
    end else if (i_diff != '0) begin
      w_mask = ONES >> (DATA_W - i_diff);
    end
  end

  assign o_sticky = |(i_man & w_mask);

endmodule

// File: rtl/fp_align_stage.sv
// Two-stage operand alignment ahead of the right shifter: unpack and order by
// magnitude, then saturate the exponent difference and precompute sticky.
module fp_align_stage #(
  parameter int unsigned SIZE_EXP   = 8,
  parameter int unsigned SIZE_MAN   = 23,
  parameter int unsigned SIZE_DATA  = 24,
  parameter int unsigned SIZE_SHIFT = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [SIZE_EXP+SIZE_MAN:0] i_op_a,
  input  logic [SIZE_EXP+SIZE_MAN:0] i_op_b,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_sign_large,
  output logic                    o_sign_small,
  output logic [SIZE_EXP-1:0]     o_exp_large,
  output logic [SIZE_DATA-1:0]    o_man_large,
  output logic [SIZE_DATA-1:0]    o_man_small,
  output logic [SIZE_SHIFT-1:0]   o_shift_number,
  output logic                    o_sticky,
  output logic                    o_swap,
  output logic                    o_special
);
  import fp_pkg::*;

  localparam logic [SIZE_EXP-1:0] SHIFT_MAX = SIZE_EXP'((1 << SIZE_SHIFT) - 1);

  logic w_s2_adv, w_in, w_s1_adv;

  fp_unpacked_t        w_a, w_b, w_large, w_small;
  logic                w_swap, w_special;
  logic [SIZE_EXP-1:0] w_diff;

  logic                r_s1_valid;
  fp_unpacked_t        r_s1_large, r_s1_small;
  logic [SIZE_EXP-1:0] r_s1_diff;
  logic                r_s1_swap, r_s1_special;

  logic                  r_s2_valid;
  logic                  r_sign_large, r_sign_small;
  logic [SIZE_EXP-1:0]   r_exp_large;
  logic [SIZE_DATA-1:0]  r_man_large, r_man_small;
  logic [SIZE_SHIFT-1:0] r_shift;
  logic                  r_sticky, r_swap, r_special;

  logic                  w_sticky;
  logic [SIZE_SHIFT-1:0] w_shift;

  // Stage 2 frees up when empty or draining; stage 1 whenever it can move on.
  assign w_s2_adv = !r_s2_valid || i_ready;
  assign o_ready  = !r_s1_valid || w_s2_adv;
  assign w_in     = i_valid && o_ready;
  assign w_s1_adv = r_s1_valid && w_s2_adv;

  always_comb begin
    w_a       = fp_unpack(i_op_a);
    w_b       = fp_unpack(i_op_b);
    w_swap    = {w_b.eff_exp, w_b.man} > {w_a.eff_exp, w_a.man};
    w_large   = w_swap ? w_b : w_a;
    w_small   = w_swap ? w_a : w_b;
    w_diff    = w_large.eff_exp - w_small.eff_exp;
    w_special = (i_op_a[SIZE_EXP+SIZE_MAN-1:SIZE_MAN] == EXP_ALL_ONES) ||
                (i_op_b[SIZE_EXP+SIZE_MAN-1:SIZE_MAN] == EXP_ALL_ONES);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_large   <= '0;
      r_s1_small   <= '0;
      r_s1_diff    <= '0;
      r_s1_swap    <= 1'b0;
      r_s1_special <= 1'b0;
    end else if (o_ready) begin
      r_s1_valid <= i_valid;
      if (w_in) begin
        r_s1_large   <= w_large;
        r_s1_small   <= w_small;
        r_s1_diff    <= w_diff;
        r_s1_swap    <= w_swap;
        r_s1_special <= w_special;
      end
    end
  end

  fp_sticky_gen #(
    .SIZE_DATA (SIZE_DATA),
    .SIZE_EXP  (SIZE_EXP)
  ) u_sticky (
    .i_man    (r_s1_small.man),
    .i_diff   (r_s1_diff),
    .o_sticky (w_sticky)
  );

  assign w_shift = (r_s1_diff > SHIFT_MAX) ? '1 : r_s1_diff[SIZE_SHIFT-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid   <= 1'b0;
      r_sign_large <= 1'b0;
      r_sign_small <= 1'b0;
      r_exp_large  <= '0;
      r_man_large  <= '0;
      r_man_small  <= '0;
      r_shift      <= '0;
      r_sticky     <= 1'b0;
      r_swap       <= 1'b0;
      r_special    <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (w_s1_adv) begin
        r_sign_large <= r_s1_large.sign;
        r_sign_small <= r_s1_small.sign;
        r_exp_large  <= r_s1_large.eff_exp;
        r_man_large  <= r_s1_large.man;
        r_man_small  <= r_s1_small.man;
        r_shift      <= w_shift;
        r_sticky     <= w_sticky;
        r_swap       <= r_s1_swap;
        r_special    <= r_s1_special;
      end
    end
  end

  assign o_valid        = r_s2_valid;
  assign o_sign_large   = r_sign_large;
  assign o_sign_small   = r_sign_small;
  assign o_exp_large    = r_exp_large;
  assign o_man_large    = r_man_large;
  assign o_man_small    = r_man_small;
  assign o_shift_number = r_shift;
  assign o_sticky       = r_sticky;
  assign o_swap         = r_swap;
  assign o_special      = r_special;

endmodule

// File: tb/tb_fp_align_stage.sv
// Self-checking bench for fp_align_stage against an arithmetic reference model.
module tb_fp_align_stage;

  typedef struct packed {
    logic        sl;
    logic        ss;
    logic [7:0]  el;
    logic [23:0] ml;
    logic [23:0] ms;
    logic [4:0]  sh;
    logic        st;
    logic        sw;
    logic        sp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [31:0] i_op_a = '0;
  logic [31:0] i_op_b = '0;
  logic        o_ready, o_valid;
  logic        o_sign_large, o_sign_small;
  logic [7:0]  o_exp_large;
  logic [23:0] o_man_large, o_man_small;
  logic [4:0]  o_shift_number;
  logic        o_sticky, o_swap, o_special;

  int checks = 0;
  int failures = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  fp_align_stage #(
    .SIZE_EXP   (8),
    .SIZE_MAN   (23),
    .SIZE_DATA  (24),
    .SIZE_SHIFT (5)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_op_a         (i_op_a),
    .i_op_b         (i_op_b),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_sign_large   (o_sign_large),
    .o_sign_small   (o_sign_small),
    .o_exp_large    (o_exp_large),
    .o_man_large    (o_man_large),
    .o_man_small    (o_man_small),
    .o_shift_number (o_shift_number),
    .o_sticky       (o_sticky),
    .o_swap         (o_swap),
    .o_special      (o_special)
  );

  function automatic vec_t obs();
    return {o_sign_large, o_sign_small, o_exp_large, o_man_large, o_man_small,
            o_shift_number, o_sticky, o_swap, o_special};
  endfunction

  // Magnitude = eff_exp * 2^24 + mantissa; sticky = remainder of mantissa mod 2^diff.
  function automatic vec_t ref_model(input logic [31:0] a, input logic [31:0] b);
    vec_t r;
    longint unsigned ea, eb, ma, mb, ka, kb, el, es, ml, ms, d;
    bit sa, sb, b_large, sl, ss;
    ea = longint'(a[30:23]);
    eb = longint'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    if (ea == 0) ea = 1; else ma = ma + 64'd8388608;
    if (eb == 0) eb = 1; else mb = mb + 64'd8388608;
    sa = a[31];
    sb = b[31];
    ka = ea * 64'd16777216 + ma;
    kb = eb * 64'd16777216 + mb;
    b_large = kb > ka;
    el = b_large ? eb : ea;  es = b_large ? ea : eb;
    ml = b_large ? mb : ma;  ms = b_large ? ma : mb;
    sl = b_large ? sb : sa;  ss = b_large ? sa : sb;
    d  = el - es;
    r.sl = sl;
    r.ss = ss;
    r.el = 8'(el);
    r.ml = 24'(ml);
    r.ms = 24'(ms);
    r.sh = (d > 31) ? 5'd31 : 5'(d);
    if (d == 0)       r.st = 1'b0;
    else if (d >= 24) r.st = (ms != 0);
    else              r.st = ((ms % (64'd1 << d)) != 0);
    r.sw = b_large;
    r.sp = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    return r;
  endfunction

  // Drives one cycle's inputs and tracks transfers; callers do the comparing.
  task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] b, input bit r,
                       output bit fired, output vec_t got, output vec_t want, output bit qerr);
    @(negedge clk);
    i_valid = v; i_op_a = a; i_op_b = b; i_ready = r;
    #1;
    fired = o_valid && i_ready;
    got   = obs();
    want  = '0;
    qerr  = 1'b0;
    if (fired) begin
      if (exp_q.size() == 0) qerr = 1'b1;
      else want = exp_q.pop_front();
    end
    if (i_valid && o_ready) exp_q.push_back(ref_model(a, b));
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    checks++;
    if (obs() !== vec_t'('0)) begin failures++; $display("FAIL reset_data got=%h want=0", obs()); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", o_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] ta [7] = '{32'h3F800000, 32'h3F000000, 32'hBF800000, 32'h4B800000,
                            32'h4B800000, 32'h7F000000, 32'h7F800000};
    logic [31:0] tb [7] = '{32'h3F000000, 32'h3F800000, 32'hBF800000, 32'h3F800001,
                            32'h3F800000, 32'h00000001, 32'h00000001};
    logic [4:0]  tsh[7] = '{5'd1, 5'd1, 5'd0, 5'd24, 5'd24, 5'd31, 5'd31};
    bit          tst[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit          tsw[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bit          tsp[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bit fired, qerr;
    vec_t got, want;
    int lat;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, ta[i], tb[i], 1'b1, fired, got, want, qerr);
      checks++;
      if (fired) begin failures++; $display("FAIL dir%0d_early got=1 want=0", i); end
      lat = 0;
      for (int n = 1; n <= 6; n++) begin
        cycle(1'b0, '0, '0, 1'b1, fired, got, want, qerr);
        if (fired) begin lat = n; break; end
      end
      checks++;
      if (lat != 2) begin failures++; $display("FAIL dir%0d_latency got=%0d want=2", i, lat); end
      checks++;
      if (qerr || got !== want) begin
        failures++; $display("FAIL dir%0d_data got=%h want=%h", i, got, want);
      end
      checks++;
      if ({got.sh, got.st, got.sw, got.sp} !== {tsh[i], tst[i], tsw[i], tsp[i]}) begin
        failures++;
        $display("FAIL dir%0d_fields got=sh%0d st%b sw%b sp%b want=sh%0d st%b sw%b sp%b", i,
                 got.sh, got.st, got.sw, got.sp, tsh[i], tst[i], tsw[i], tsp[i]);
      end
    end
    checks++;
    if (got.ms !== 24'h000001) begin failures++; $display("FAIL dir_denorm_man got=%h want=000001", got.ms); end
  endtask

  task automatic test_random();
    bit fired, qerr, v, r;
    vec_t got, want;
    logic [31:0] a, b;
    logic [7:0] eb;
    for (int k = 0; k < 400; k++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = {a[31:23], 23'($urandom)};
        2: b = {1'($urandom), 8'h00, 23'($urandom_range(0, 3))};
        default: begin
          eb = a[30:23] - 8'd28 + 8'($urandom_range(0, 56));
          b  = {1'($urandom), eb, 23'($urandom)};
        end
      endcase
      cycle(v, a, b, r, fired, got, want, qerr);
      if (fired) begin
        checks++;
        if (qerr || got !== want) begin
          failures++; $display("FAIL rand_data cyc=%0d got=%h want=%h", k, got, want);
        end
      end
    end
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, '0, '0, 1'b1, fired, got, want, qerr);
      if (fired) begin
        checks++;
        if (qerr || got !== want) begin
          failures++; $display("FAIL rand_drain got=%h want=%h", got, want);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rand_lost got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] oa [6], ob [6];
    bit fired, qerr, r, saw_low;
    vec_t got, want, held;
    int idx, total, rel;
    for (int i = 0; i < 6; i++) begin
      oa[i] = {1'($urandom), 8'd120 + 8'($urandom_range(0, 15)), 23'($urandom)};
      ob[i] = {1'($urandom), 8'd120 + 8'($urandom_range(0, 15)), 23'($urandom)};
    end
    idx = 0; total = 0; rel = 0; saw_low = 0; held = '0;
    for (int k = 0; k < 16; k++) begin
      r = !(k >= 3 && k <= 7);
      cycle(idx < 6, oa[idx % 6], ob[idx % 6], r, fired, got, want, qerr);
      if (idx < 6 && o_ready) idx++;
      if (k <= 2) begin
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_fill k=%0d got=%b want=1", k, o_ready); end
      end
      if (k >= 3 && k <= 7) begin
        if (!o_ready) saw_low = 1;
        checks++;
        if (o_valid !== 1'b1) begin failures++; $display("FAIL b2b_stall_valid k=%0d got=%b want=1", k, o_valid); end
        if (k == 3) held = got;
        else begin
          checks++;
          if (got !== held) begin failures++; $display("FAIL b2b_stable k=%0d got=%h want=%h", k, got, held); end
        end
      end
      if (fired) begin
        total++;
        if (k >= 8 && k <= 12) rel++;
        checks++;
        if (qerr || got !== want) begin
          failures++; $display("FAIL b2b_data k=%0d got=%h want=%h", k, got, want);
        end
      end
    end
    checks++;
    if (!saw_low) begin failures++; $display("FAIL b2b_ready_low got=1 want=0"); end
    checks++;
    if (rel != 5) begin failures++; $display("FAIL b2b_release_rate got=%0d want=5", rel); end
    checks++;
    if (total != 6) begin failures++; $display("FAIL b2b_total got=%0d want=6", total); end
  endtask

  task automatic test_reset_midflight();
    bit fired, qerr;
    vec_t got, want;
    cycle(1'b1, 32'h40400000, 32'h3F800000, 1'b0, fired, got, want, qerr);
    cycle(1'b1, 32'hC1200000, 32'h41200001, 1'b0, fired, got, want, qerr);
    cycle(1'b0, '0, '0, 1'b0, fired, got, want, qerr);
    checks++;
    if ({o_valid, o_ready} !== 2'b10) begin
      failures++; $display("FAIL rst_full got=%b want=10", {o_valid, o_ready});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b want=0", o_valid); end
    checks++;
    if (obs() !== vec_t'('0)) begin failures++; $display("FAIL rst_async_data got=%h want=0", obs()); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, '0, '0, 1'b1, fired, got, want, qerr);
      checks++;
      if ({o_valid, o_ready} !== 2'b01) begin
        failures++; $display("FAIL rst_after k=%0d got=%b want=01", k, {o_valid, o_ready});
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
